// File: rtl/exponent_adjust.sv
// -----------------------------------------------------------------------------
// exponent_adjust
//
// Final exponent stage of the FP multiply/divide datapath. It takes the biased
// intermediate exponent from exponent_logic and applies the mantissa
// normalisation correction: +1 after a product carry, -1 after a quotient
// left-shift. It then range-checks the result and produces the 8-bit
// single-precision exponent with overflow and underflow flags.
//
// The block is a two-entry valid/ready pipeline:
//   S1 holds the corrected exponent (IW+1 bits, signed).
//   S2 holds the classified result.
// Two saturating counters record the overflow and underflow results that are
// actually delivered downstream.
//
// Ports
//   clk        rising-edge clock
//   arst       synchronous active-high reset (name kept for upstream compat)
//   in_valid   upstream data valid          in_ready   block can accept
//   e_in       biased exponent, two's complement, IW bits
//   norm_inc   add 1 to the exponent        norm_dec   subtract 1
//   out_valid  result valid                 out_ready  downstream accepts
//   e_out      final exponent, EW bits
//   ovf        result saturated to all-ones (infinity)
//   unf        result flushed to zero
//   cnt_clr    synchronous clear of both counters; wins over an increment
//   ovf_cnt    saturating count of delivered ovf results
//   unf_cnt    saturating count of delivered unf results
// -----------------------------------------------------------------------------
module exponent_adjust #(
    parameter int EW   = 8,
    parameter int IW   = 10,
    parameter int EMAX = 255,
    parameter int CW   = 16
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] e_in,
    input  logic          norm_inc,
    input  logic          norm_dec,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] e_out,
    output logic          ovf,
    output logic          unf,
    input  logic          cnt_clr,
    output logic [CW-1:0] ovf_cnt,
    output logic [CW-1:0] unf_cnt
);

    // One extra bit so that e_in at its positive limit plus the +1
    // correction cannot wrap into the negative range.
    localparam int SW = IW + 1;

    localparam logic signed [SW-1:0] EMAX_S = SW'(EMAX);
    localparam logic signed [SW-1:0] ZERO_S = '0;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                 s1_valid_q, s1_valid_d;
    logic signed [SW-1:0] s1_e_q, s1_e_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [EW-1:0]        e_out_q, e_out_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    logic                 s2_load;
    logic                 out_xfer;
    logic signed [SW-1:0] e_sum;

    // S2 can take a new entry when it is empty or is being drained this
    // cycle. S1 follows the same rule, using S2's readiness, so a full pipe
    // still takes one input per cycle without a bubble.
    assign out_xfer = s2_valid_q & out_ready;
    assign s2_load  = ~s2_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s2_load;

    // Two's-complement sign extension followed by the correction. When both
    // norm_inc and norm_dec are set, the two corrections cancel.
    assign e_sum = {e_in[IW-1], e_in} + SW'(norm_inc) - SW'(norm_dec);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_e_d     = s1_e_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_e_d = e_sum;
            end
        end
    end

    // Classification. Overflow is tested first, so EMAX itself saturates.
    // Zero and negative values flush to zero because subnormals are not
    // produced here. The data fields keep their last value when S2 drains
    // without a refill, so only the valid bit changes.
    always_comb begin
        s2_valid_d = s2_valid_q;
        e_out_d    = e_out_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (s1_e_q >= EMAX_S) begin
                    e_out_d = {EW{1'b1}};
                    ovf_d   = 1'b1;
                    unf_d   = 1'b0;
                end else if (s1_e_q <= ZERO_S) begin
                    e_out_d = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b1;
                end else begin
                    e_out_d = s1_e_q[EW-1:0];
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            s1_valid_q <= 1'b0;
            s1_e_q     <= '0;
            s2_valid_q <= 1'b0;
            e_out_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_e_q     <= s1_e_d;
            s2_valid_q <= s2_valid_d;
            e_out_q    <= e_out_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign e_out     = e_out_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

    // ------------------------------------------------------------------
    // Exception counters: index 0 counts ovf, index 1 counts unf.
    // Each counter only counts results that are handed downstream.
    // ------------------------------------------------------------------
    logic [1:0] cnt_flag;
    assign cnt_flag = {unf_q, ovf_q};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (cnt_clr) begin
                cnt_d = '0;
            end else if (out_xfer && cnt_flag[gi] && (cnt_q != {CW{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (arst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign ovf_cnt = g_cnt[0].cnt_q;
    assign unf_cnt = g_cnt[1].cnt_q;

endmodule

// File: tb/tb_exponent_adjust.sv
// -----------------------------------------------------------------------------
// tb_exponent_adjust
//
// Self-checking bench for exponent_adjust.
//
// Inputs are driven on the falling edge and the DUT is sampled 1 ns later,
// before the next rising edge. The reference model works out each expected
// result with integer arithmetic at the moment the input handshake happens,
// then pushes it onto a queue. Every output handshake pops one entry from
// the queue and compares it. The exception counters are modelled alongside.
// -----------------------------------------------------------------------------
module tb_exponent_adjust;

    localparam int EW = 8;
    localparam int IW = 10;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] e_in = '0;
    logic          norm_inc = 1'b0;
    logic          norm_dec = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [EW-1:0] e_out;
    logic          ovf;
    logic          unf;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] ovf_cnt;
    logic [CW-1:0] unf_cnt;

    always #5 clk = ~clk;

    exponent_adjust #(.EW(EW), .IW(IW), .EMAX(255), .CW(CW)) dut (
        .clk      (clk),
        .arst     (arst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .e_in     (e_in),
        .norm_inc (norm_inc),
        .norm_dec (norm_dec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .e_out    (e_out),
        .ovf      (ovf),
        .unf      (unf),
        .cnt_clr  (cnt_clr),
        .ovf_cnt  (ovf_cnt),
        .unf_cnt  (unf_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] e;
        logic       o;
        logic       u;
        int         cyc;
    } exp_t;

    exp_t     sb[$];
    int       m_ovf_cnt = 0;
    int       m_unf_cnt = 0;
    int       cyc = 0;
    bit       lat_chk = 0;
    logic     last_ir = 1'b0;
    bit       held = 0;
    exp_t     held_x;

    function automatic exp_t model(input logic [9:0] e, input logic inc, input logic dec);
        exp_t r;
        int   v;
        v = int'($signed(e)) + int'(inc) - int'(dec);
        if (v >= 255) begin
            r.e = 8'hFF; r.o = 1'b1; r.u = 1'b0;
        end else if (v <= 0) begin
            r.e = 8'h00; r.o = 1'b0; r.u = 1'b1;
        end else begin
            r.e = v[7:0]; r.o = 1'b0; r.u = 1'b0;
        end
        r.cyc = 0;
        return r;
    endfunction

    // One clock cycle: drive on the falling edge, then sample and score.
    task automatic step(input logic rst, input logic iv, input logic [9:0] e,
                        input logic inc, input logic dec, input logic ordy,
                        input logic clr);
        exp_t x;
        bit   xfer_o;
        bit   xfer_u;
        @(negedge clk);
        arst = rst; in_valid = iv; e_in = e; norm_inc = inc; norm_dec = dec;
        out_ready = ordy; cnt_clr = clr;
        #1;
        cyc++;
        last_ir = in_ready;
        if (rst) begin
            sb.delete();
            m_ovf_cnt = 0;
            m_unf_cnt = 0;
            held = 0;
            return;
        end
        check("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf_cnt));
        check("unf_cnt", 32'(unf_cnt), 32'(m_unf_cnt));
        if (held) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_e_out", 32'(e_out), 32'(held_x.e));
            check("hold_ovf", 32'(ovf), 32'(held_x.o));
            check("hold_unf", 32'(unf), 32'(held_x.u));
        end
        xfer_o = 0;
        xfer_u = 0;
        if (out_valid && sb.size() == 0) begin
            check("out_valid_unexpected", 32'(out_valid), 32'd0);
        end else if (out_valid && out_ready) begin
            x = sb.pop_front();
            check("e_out", 32'(e_out), 32'(x.e));
            check("ovf", 32'(ovf), 32'(x.o));
            check("unf", 32'(unf), 32'(x.u));
            if (lat_chk) check("latency", 32'(cyc - x.cyc), 32'd2);
            xfer_o = x.o;
            xfer_u = x.u;
        end
        if (clr) begin
            m_ovf_cnt = 0;
            m_unf_cnt = 0;
        end else begin
            if (xfer_o && m_ovf_cnt < 65535) m_ovf_cnt++;
            if (xfer_u && m_unf_cnt < 65535) m_unf_cnt++;
        end
        held = out_valid && !out_ready && (sb.size() != 0);
        if (held) held_x = sb[0];
        if (iv && in_ready) begin
            x = model(e, inc, dec);
            x.cyc = cyc;
            sb.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : main
        logic [9:0] t4_vals [3];
        int         idx;
        logic       r_iv, r_inc, r_dec, r_ordy, r_clr;
        logic [9:0] r_e;
        int         sel;

        // Reset and reset state.
        step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_e_out", 32'(e_out), 32'd0);
        check("rst_flags", {30'd0, ovf, unf}, 32'd0);

        // 1: back-to-back normal results with the 2-cycle latency check.
        lat_chk = 1;
        step(1'b0, 1'b1, 10'd200, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 10'd200, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(4);

        // 2: overflow after a carry and from a large input.
        step(1'b0, 1'b1, 10'd254, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 10'd300, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("t2_ovf_cnt", 32'(ovf_cnt), 32'd2);

        // 3: underflow cases and cancelling corrections.
        step(1'b0, 1'b1, 10'h381, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 10'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 10'd255, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 10'd255, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 10'h200, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 10'h1FF, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("t3_unf_cnt", 32'(unf_cnt), 32'd3);
        lat_chk = 0;

        // 4: backpressure. Capacity is two entries, and order is preserved.
        t4_vals[0] = 10'd10; t4_vals[1] = 10'd11; t4_vals[2] = 10'd12;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, t4_vals[idx], 1'b0, 1'b0, 1'b0, 1'b0);
            if (last_ir) idx++;
        end
        check("t4_accepts", 32'(idx), 32'd2);
        check("t4_in_ready", 32'(last_ir), 32'd0);
        for (int i = 0; i < 8 && idx < 3; i++) begin
            step(1'b0, 1'b1, t4_vals[idx], 1'b0, 1'b0, 1'b1, 1'b0);
            if (last_ir) idx++;
        end
        idle(4);
        check("t4_drain", 32'(sb.size()), 32'd0);

        // 5: reset with both stages full.
        step(1'b0, 1'b1, 10'd300, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_full", 32'(in_ready), 32'd0);
        step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd1);
        check("t5_ovf_cnt", 32'(ovf_cnt), 32'd0);
        check("t5_unf_cnt", 32'(unf_cnt), 32'd0);
        idle(4);

        // Randomized traffic. Upstream holds its data while stalled.
        r_iv = 0; r_e = '0; r_inc = 0; r_dec = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!(r_iv && !last_ir)) begin
                r_iv  = ($urandom_range(0, 3) != 0);
                r_inc = $urandom_range(0, 1) == 1;
                r_dec = $urandom_range(0, 1) == 1;
                sel   = $urandom_range(0, 3);
                case (sel)
                    0:       r_e = 10'($urandom);
                    1:       r_e = 10'($urandom_range(250, 260));
                    2:       r_e = 10'($urandom_range(0, 4) - 2);
                    default: r_e = 10'($urandom_range(1, 254));
                endcase
            end
            r_ordy = ($urandom_range(0, 3) != 0);
            r_clr  = ($urandom_range(0, 199) == 0);
            step(1'b0, r_iv, r_e, r_inc, r_dec, r_ordy, r_clr);
        end
        idle(4);
        check("rand_drain", 32'(sb.size()), 32'd0);

        // 6: counter saturation, then a clear that coincides with an ovf transfer.
        step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 65540; i++) begin
            step(1'b0, 1'b1, 10'd300, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("t6_sat", 32'(ovf_cnt), 32'hFFFF);
        check("t6_clr_xfer_live", 32'(out_valid), 32'd1);
        step(1'b0, 1'b1, 10'd300, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_clr", 32'(ovf_cnt), 32'd0);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
